// File: rtl/register_pipe.sv
// rtl/register_pipe.sv - elastic DEPTH-stage valid/ready pipeline register with bubble collapsing
// Optional synchronous flush input when REGISTER_PIPE_FLUSH_EN is defined.
module register_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef REGISTER_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    occupancy
);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("register_pipe: DEPTH must be >= 1");
    end
  endgenerate

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [CW-1:0]    r_occ;

  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_valid_nxt;
  logic [WIDTH-1:0] w_data_nxt [DEPTH];
  logic             w_flush;

`ifdef REGISTER_PIPE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  function automatic logic [CW-1:0] f_popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  // Ready ripples back from the output: an empty stage always accepts.
  always_comb begin
    logic w_chain;
    w_chain = ~r_valid[DEPTH-1] | out_ready;
    w_rdy = '0;
    w_rdy[DEPTH-1] = w_chain;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_chain = ~r_valid[i] | w_chain;
      w_rdy[i] = w_chain;
    end
  end

  always_comb begin
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    if (w_rdy[0]) begin
      w_valid_nxt[0] = in_valid;
      if (in_valid) w_data_nxt[0] = in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (w_rdy[i]) begin
        w_valid_nxt[i] = r_valid[i-1];
        if (r_valid[i-1]) w_data_nxt[i] = r_data[i-1];
      end
    end
    // Flush drops every word but leaves data registers untouched.
    if (w_flush) begin
      w_valid_nxt = '0;
      w_data_nxt  = r_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_occ   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_occ   <= f_popcount(w_valid_nxt);
    end
  end

  assign in_ready  = w_rdy[0] & ~w_flush;
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_register_pipe.sv
// tb/tb_register_pipe.sv - directed self-checking bench for register_pipe (WIDTH=32, DEPTH=2)
module tb_register_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic        flush;

  int errors = 0;
  int checks = 0;

  register_pipe #(.WIDTH(32), .DEPTH(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
`ifdef REGISTER_PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output must hold while stalled across an edge.
  logic        p_hold = 1'b0;
  logic [31:0] p_data;
  always @(negedge clk) begin
    if (p_hold) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", out_data, p_data);
    end
    p_hold = out_valid & ~out_ready & ~rst & ~flush;
    p_data = out_data;
  end

  logic [31:0] stream [3];

  initial begin
    stream[0] = 32'h12345678;
    stream[1] = 32'hABCDEF00;
    stream[2] = 32'hDEADBEEF;
    flush     = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hFFFFFFFF;
    out_ready = 1'b1;

    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_occ", {30'd0, occupancy}, 32'd0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming at full rate.
    for (int k = 0; k < 5; k++) begin
      in_valid = (k < 3);
      in_data  = (k < 3) ? stream[k] : 32'd0;
      tick();
      if (k >= 1 && k <= 3) begin
        check("stream_valid", {31'd0, out_valid}, 32'd1);
        check("stream_data", out_data, stream[k-1]);
      end else begin
        check("stream_gap", {31'd0, out_valid}, 32'd0);
      end
    end
    tick();
    check("stream_empty_occ", {30'd0, occupancy}, 32'd0);

    // Back-pressure.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hCAFEBABE;
    tick();
    in_data = 32'hFEEDFACE;
    tick();
    in_valid = 1'b0;
    #1;
    check("bp_occ", {30'd0, occupancy}, 32'd2);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_data", out_data, 32'hCAFEBABE);
      check("bp_occ_hold", {30'd0, occupancy}, 32'd2);
    end
    out_ready = 1'b1;
    tick();
    check("bp_drain1", out_data, 32'hFEEDFACE);
    check("bp_drain1_occ", {30'd0, occupancy}, 32'd1);
    tick();
    check("bp_drain2_valid", {31'd0, out_valid}, 32'd0);
    check("bp_drain2_occ", {30'd0, occupancy}, 32'd0);

    // Full pipe with simultaneous accept and emit.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h11111111;
    tick();
    in_data = 32'h22222222;
    tick();
    check("full_occ", {30'd0, occupancy}, 32'd2);
    out_ready = 1'b1;
    in_data = 32'h00000001;
    #1;
    check("full_pass_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("full_pass_occ", {30'd0, occupancy}, 32'd2);
    check("full_pass_data", out_data, 32'h22222222);
    tick();
    check("full_pass_last", out_data, 32'h00000001);
    check("full_pass_occ1", {30'd0, occupancy}, 32'd1);
    tick();
    check("full_pass_empty", {30'd0, occupancy}, 32'd0);

    // Reset while full.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h33333333;
    tick();
    in_data = 32'h44444444;
    tick();
    check("mid_full_occ", {30'd0, occupancy}, 32'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_occ", {30'd0, occupancy}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h80000000;
    tick();
    in_valid = 1'b0;
    check("mid_lat_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("mid_word_valid", {31'd0, out_valid}, 32'd1);
    check("mid_word_data", out_data, 32'h80000000);
    tick();
    check("mid_alone", {31'd0, out_valid}, 32'd0);

`ifdef REGISTER_PIPE_FLUSH_EN
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h7FFFFFFF;
    tick();
    flush = 1'b1;
    in_data = 32'h55555555;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("flush_occ", {30'd0, occupancy}, 32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_no_emit", {31'd0, out_valid}, 32'd0);
    end
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
